// File: rtl/rnd_sat_arb.sv
// Round-robin arbiter sharing one rounding/saturating shifter among NumReq requesters,
// with per-requester config and a 2-entry result FIFO.
package math_pkg;
    typedef enum logic [1:0] {
        DIRECT_DOWN  = 2'd0,
        DIRECT_UP    = 2'd1,
        NEAREST_UP   = 2'd2,
        NEAREST_EVEN = 2'd3
    } round_mode_e;
endpackage

module rnd_sat
    import math_pkg::*;
#(
    parameter int InDw    = 16,
    parameter int OutDw   = 8,
    parameter int ShiftDw = 3
) (
    input  logic [InDw-1:0]    data_i,
    input  logic               tc_i,
    input  logic               sat_i,
    input  round_mode_e        round_i,
    input  logic [ShiftDw-1:0] shift_i,
    output logic [OutDw-1:0]   data_o
);
    // Two guard bits keep the rounding increment of a full-scale unsigned input from overflowing.
    localparam int W = InDw + 2;
    localparam logic signed [W-1:0] MaxS = W'((1 << (OutDw - 1)) - 1);
    localparam logic signed [W-1:0] MinS = -MaxS - W'(1);
    localparam logic signed [W-1:0] MaxU = W'((1 << OutDw) - 1);

    logic signed [W-1:0] ext, quo, rnd;
    logic        [W-1:0] mask, rem, half;
    logic                inc;

    always_comb begin
        ext  = tc_i ? {{2{data_i[InDw-1]}}, data_i} : {2'b00, data_i};
        quo  = ext >>> shift_i;
        mask = (W'(1) << shift_i) - W'(1);
        rem  = ext & mask;
        half = (shift_i == '0) ? '0 : (W'(1) << (shift_i - ShiftDw'(1)));
        inc  = 1'b0;
        case (round_i)
            DIRECT_DOWN:  inc = 1'b0;
            DIRECT_UP:    inc = (rem != '0);
            NEAREST_UP:   inc = (shift_i != '0) && (rem >= half);
            NEAREST_EVEN: inc = (shift_i != '0) && ((rem > half) || ((rem == half) && quo[0]));
            default:      inc = 1'b0;
        endcase
        rnd = quo + $signed({{(W-1){1'b0}}, inc});
        data_o = rnd[OutDw-1:0];
        if (sat_i) begin
            if (tc_i) begin
                if (rnd > MaxS)      data_o = MaxS[OutDw-1:0];
                else if (rnd < MinS) data_o = MinS[OutDw-1:0];
            end else if (rnd > MaxU) begin
                data_o = '1;
            end
        end
    end
endmodule

module rnd_sat_arb
    import math_pkg::*;
#(
    parameter int NumReq  = 4,
    parameter int InDw    = 16,
    parameter int OutDw   = 8,
    parameter int ShiftDw = 3,
    localparam int IdxW   = $clog2(NumReq)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_we_i,
    input  logic [IdxW-1:0]        cfg_idx_i,
    input  logic                   cfg_tc_i,
    input  logic                   cfg_sat_i,
    input  round_mode_e            cfg_round_i,
    input  logic [ShiftDw-1:0]     cfg_shift_i,
    input  logic [NumReq-1:0]      req_valid_i,
    input  logic [NumReq*InDw-1:0] req_data_i,
    output logic [NumReq-1:0]      req_ready_o,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [OutDw-1:0]       rsp_data_o,
    output logic [IdxW-1:0]        rsp_id_o
);
    logic [NumReq-1:0]  tc_q, sat_q;
    round_mode_e        round_q [NumReq];
    logic [ShiftDw-1:0] shift_q [NumReq];

    logic [IdxW-1:0]  ptr_q, ptr_d, sel;
    logic [IdxW:0]    cand;
    logic             found, grant, pop;
    logic [1:0]       cnt_q, cnt_d;
    logic [OutDw-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d, res;
    logic [IdxW-1:0]  head_id_q, head_id_d, tail_id_q, tail_id_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tc_q  <= '0;
            sat_q <= '1;
            for (int k = 0; k < NumReq; k++) begin
                round_q[k] <= DIRECT_DOWN;
                shift_q[k] <= '0;
            end
        end else if (cfg_we_i) begin
            tc_q[cfg_idx_i]    <= cfg_tc_i;
            sat_q[cfg_idx_i]   <= cfg_sat_i;
            round_q[cfg_idx_i] <= cfg_round_i;
            shift_q[cfg_idx_i] <= cfg_shift_i;
        end
    end

    // First valid requester at or after the pointer, wrapping modulo NumReq.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand = {1'b0, ptr_q} + (IdxW+1)'(i);
            if (cand >= (IdxW+1)'(NumReq)) cand = cand - (IdxW+1)'(NumReq);
            if (!found && req_valid_i[cand[IdxW-1:0]]) begin
                found = 1'b1;
                sel   = cand[IdxW-1:0];
            end
        end
    end

    assign grant       = found && (cnt_q != 2'd2) && !rst_i;
    assign req_ready_o = grant ? (NumReq'(1) << sel) : '0;
    assign ptr_d       = !grant ? ptr_q : (sel == IdxW'(NumReq - 1)) ? '0 : sel + IdxW'(1);

    rnd_sat #(.InDw(InDw), .OutDw(OutDw), .ShiftDw(ShiftDw)) u_rnd_sat (
        .data_i  (req_data_i[sel*InDw +: InDw]),
        .tc_i    (tc_q[sel]),
        .sat_i   (sat_q[sel]),
        .round_i (round_q[sel]),
        .shift_i (shift_q[sel]),
        .data_o  (res)
    );

    assign pop = (cnt_q != 2'd0) && rsp_ready_i;

    always_comb begin
        cnt_d       = cnt_q;
        head_data_d = head_data_q;
        head_id_d   = head_id_q;
        tail_data_d = tail_data_q;
        tail_id_d   = tail_id_q;
        if (pop) begin
            head_data_d = tail_data_q;
            head_id_d   = tail_id_q;
            cnt_d       = cnt_q - 2'd1;
        end
        // After an optional pop, the new result lands in the first free slot.
        if (grant) begin
            if (cnt_d == 2'd0) begin
                head_data_d = res;
                head_id_d   = sel;
            end else begin
                tail_data_d = res;
                tail_id_d   = sel;
            end
            cnt_d = cnt_d + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q       <= '0;
            cnt_q       <= '0;
            head_data_q <= '0;
            head_id_q   <= '0;
            tail_data_q <= '0;
            tail_id_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            head_data_q <= head_data_d;
            head_id_q   <= head_id_d;
            tail_data_q <= tail_data_d;
            tail_id_q   <= tail_id_d;
        end
    end

    assign rsp_valid_o = (cnt_q != 2'd0);
    assign rsp_data_o  = head_data_q;
    assign rsp_id_o    = head_id_q;
endmodule
